// File: rtl/clock_timekeeper.sv
// rtl/clock_timekeeper.sv - 24-hour BCD timekeeper with prescaler, debounced set buttons and HH:MM load port
module clock_timekeeper #(
    parameter int CLK_HZ   = 27000000,
    parameter int DEBOUNCE = 270000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic       btn_h,
    input  logic       btn_m,
    input  logic       ld_valid,
    output logic       ld_ready,
    input  logic [3:0] ld_hh,
    input  logic [3:0] ld_hl,
    input  logic [3:0] ld_mh,
    input  logic [3:0] ld_ml,
    output logic       ld_err,
    output logic [3:0] hh,
    output logic [3:0] hl,
    output logic [3:0] mh,
    output logic [3:0] ml,
    output logic [3:0] sh,
    output logic [3:0] sl,
    output logic       dots_on,
    output logic       sec_tick
);

    localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int DW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam logic [PW-1:0] P_MAX  = PW'(CLK_HZ - 1);
    localparam logic [PW-1:0] P_HALF = PW'(CLK_HZ / 2);
    localparam logic [DW-1:0] D_MAX  = DW'(DEBOUNCE - 1);

    logic [PW-1:0] presc;
    logic [PW-1:0] presc_next;
    logic          presc_adv;
    logic          wrap;
    logic          ld_ok;
    logic          ld_bad;

    logic [1:0]    sync1;
    logic [1:0]    sync2;
    logic [1:0]    deb;
    logic [DW-1:0] deb_cnt [2];
    logic [1:0]    btn_rise;
    logic          inc_h;
    logic          inc_m;

    logic [3:0] n_hh, n_hl, n_mh, n_ml, n_sh, n_sl;

    // Hour and minute increments wrap within their own field; callers decide on carry.
    function automatic logic [7:0] hour_inc(input logic [3:0] h1, input logic [3:0] h0);
        if (h1 == 4'd2 && h0 == 4'd3)
            return 8'h00;
        else if (h0 == 4'd9)
            return {h1 + 4'd1, 4'd0};
        else
            return {h1, h0 + 4'd1};
    endfunction

    function automatic logic [7:0] min_inc(input logic [3:0] m1, input logic [3:0] m0);
        if (m0 != 4'd9)
            return {m1, m0 + 4'd1};
        else if (m1 == 4'd5)
            return 8'h00;
        else
            return {m1 + 4'd1, 4'd0};
    endfunction

    assign ld_ready = rst_n;

    assign ld_ok  = ld_valid && (ld_hh <= 4'd2) && (ld_hl <= 4'd9) && (ld_mh <= 4'd5)
                    && (ld_ml <= 4'd9) && (ld_hh != 4'd2 || ld_hl <= 4'd3);
    assign ld_bad = ld_valid && !ld_ok;
    assign wrap   = run && (presc == P_MAX);

    // A new debounced level is accepted on the edge where the run of differing samples completes.
    always_comb begin
        for (int k = 0; k < 2; k++) begin
            btn_rise[k] = sync2[k] && !deb[k] && (deb_cnt[k] == D_MAX);
        end
    end

    assign inc_h = btn_rise[0];
    assign inc_m = btn_rise[1];

    always_comb begin
        presc_adv  = ld_ok || (run && !ld_bad);
        presc_next = presc;
        if (ld_ok)
            presc_next = '0;
        else if (run && !ld_bad)
            presc_next = wrap ? '0 : presc + PW'(1);
    end

    always_comb begin
        n_hh = hh;
        n_hl = hl;
        n_mh = mh;
        n_ml = ml;
        n_sh = sh;
        n_sl = sl;
        if (ld_valid) begin
            if (ld_ok) begin
                n_hh = ld_hh;
                n_hl = ld_hl;
                n_mh = ld_mh;
                n_ml = ld_ml;
                n_sh = 4'd0;
                n_sl = 4'd0;
            end
        end else if (inc_h || inc_m) begin
            if (inc_m)
                {n_mh, n_ml} = min_inc(mh, ml);
            if (inc_h)
                {n_hh, n_hl} = hour_inc(hh, hl);
        end else if (wrap) begin
            if (sl != 4'd9) begin
                n_sl = sl + 4'd1;
            end else begin
                n_sl = 4'd0;
                if (sh != 4'd5) begin
                    n_sh = sh + 4'd1;
                end else begin
                    n_sh = 4'd0;
                    {n_mh, n_ml} = min_inc(mh, ml);
                    if (mh == 4'd5 && ml == 4'd9)
                        {n_hh, n_hl} = hour_inc(hh, hl);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
            deb   <= '0;
            for (int k = 0; k < 2; k++)
                deb_cnt[k] <= '0;
        end else begin
            sync1 <= {btn_m, btn_h};
            sync2 <= sync1;
            for (int k = 0; k < 2; k++) begin
                if (sync2[k] == deb[k]) begin
                    deb_cnt[k] <= '0;
                end else if (deb_cnt[k] == D_MAX) begin
                    deb[k]     <= sync2[k];
                    deb_cnt[k] <= '0;
                end else begin
                    deb_cnt[k] <= deb_cnt[k] + DW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc    <= '0;
            sec_tick <= 1'b0;
            dots_on  <= 1'b0;
            ld_err   <= 1'b0;
            hh       <= 4'd0;
            hl       <= 4'd0;
            mh       <= 4'd0;
            ml       <= 4'd0;
            sh       <= 4'd0;
            sl       <= 4'd0;
        end else begin
            presc    <= presc_next;
            // A rejected load freezes the prescaler, so its wrap must not pulse twice.
            sec_tick <= wrap && !ld_bad;
            if (presc_adv)
                dots_on <= (presc_next < P_HALF);
            ld_err   <= ld_bad;
            hh       <= n_hh;
            hl       <= n_hl;
            mh       <= n_mh;
            ml       <= n_ml;
            sh       <= n_sh;
            sl       <= n_sl;
        end
    end

endmodule

// File: tb/tb_clock_timekeeper.sv
// tb/tb_clock_timekeeper.sv - directed self-checking bench for clock_timekeeper (CLK_HZ=10, DEBOUNCE=4)
module tb_clock_timekeeper;

    logic       clk;
    logic       rst_n;
    logic       run;
    logic       btn_h;
    logic       btn_m;
    logic       ld_valid;
    logic       ld_ready;
    logic [3:0] ld_hh, ld_hl, ld_mh, ld_ml;
    logic       ld_err;
    logic [3:0] hh, hl, mh, ml, sh, sl;
    logic       dots_on;
    logic       sec_tick;

    int total;
    int bad;
    int dots_high;
    int range_bad;

    clock_timekeeper #(.CLK_HZ(10), .DEBOUNCE(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .run      (run),
        .btn_h    (btn_h),
        .btn_m    (btn_m),
        .ld_valid (ld_valid),
        .ld_ready (ld_ready),
        .ld_hh    (ld_hh),
        .ld_hl    (ld_hl),
        .ld_mh    (ld_mh),
        .ld_ml    (ld_ml),
        .ld_err   (ld_err),
        .hh       (hh),
        .hl       (hl),
        .mh       (mh),
        .ml       (ml),
        .sh       (sh),
        .sl       (sl),
        .dots_on  (dots_on),
        .sec_tick (sec_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] now_t();
        return {hh, hl, mh, ml, sh, sl};
    endfunction

    task automatic do_load(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c, input logic [3:0] d);
        @(negedge clk);
        ld_valid = 1'b1;
        ld_hh = a;
        ld_hl = b;
        ld_mh = c;
        ld_ml = d;
        @(negedge clk);
        ld_valid = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++)
            @(negedge clk);
    endtask

    initial begin
        total = 0;
        bad = 0;
        rst_n = 1'b0;
        run = 1'b0;
        btn_h = 1'b0;
        btn_m = 1'b0;
        ld_valid = 1'b0;
        ld_hh = 4'd0;
        ld_hl = 4'd0;
        ld_mh = 4'd0;
        ld_ml = 4'd0;

        #12;
        check_eq("rst_time", {8'h0, now_t()}, 32'h0);
        check_eq("rst_tick", {31'd0, sec_tick}, 32'd0);
        check_eq("rst_dots", {31'd0, dots_on}, 32'd0);
        check_eq("rst_ready", {31'd0, ld_ready}, 32'd0);
        check_eq("rst_err", {31'd0, ld_err}, 32'd0);

        // first seconds after release
        @(negedge clk);
        rst_n = 1'b1;
        run = 1'b1;
        dots_high = 0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            check_eq($sformatf("tick_c%0d", i), {31'd0, sec_tick}, (i % 10 == 0) ? 32'd1 : 32'd0);
            if (dots_on)
                dots_high++;
        end
        check_eq("dots_high30", dots_high, 32'd15);
        check_eq("time_30c", {8'h0, now_t()}, 32'h000003);
        check_eq("ready_run", {31'd0, ld_ready}, 32'd1);

        // midnight rollover
        do_load(4'd2, 4'd3, 4'd5, 4'd9);
        check_eq("load_2359", {8'h0, now_t()}, 32'h235900);
        range_bad = 0;
        for (int i = 1; i <= 600; i++) begin
            @(negedge clk);
            if (sl > 9 || sh > 5 || ml > 9 || mh > 5 || hl > 9 || hh > 2 || (hh == 2 && hl > 3))
                range_bad++;
            if (i == 590)
                check_eq("t_235959", {8'h0, now_t()}, 32'h235959);
            if (i == 600) begin
                check_eq("t_000000", {8'h0, now_t()}, 32'h000000);
                check_eq("tick_600", {31'd0, sec_tick}, 32'd1);
            end
        end
        check_eq("range_bad", range_bad, 32'd0);
        run = 1'b0;

        // load validation
        do_load(4'd2, 4'd4, 4'd0, 4'd0);
        check_eq("ld24_time", {8'h0, now_t()}, 32'h000000);
        check_eq("ld24_err", {31'd0, ld_err}, 32'd1);
        @(negedge clk);
        check_eq("ld24_err_clr", {31'd0, ld_err}, 32'd0);
        do_load(4'd1, 4'd2, 4'd6, 4'd0);
        check_eq("ld1260_time", {8'h0, now_t()}, 32'h000000);
        check_eq("ld1260_err", {31'd0, ld_err}, 32'd1);
        @(negedge clk);
        check_eq("ld1260_err_clr", {31'd0, ld_err}, 32'd0);
        do_load(4'd0, 4'd9, 4'd3, 4'd0);
        check_eq("ld0930_time", {8'h0, now_t()}, 32'h093000);
        check_eq("ld0930_err", {31'd0, ld_err}, 32'd0);
        do_load(4'd2, 4'd4, 4'd0, 4'd0);
        check_eq("ld24b_time", {8'h0, now_t()}, 32'h093000);
        check_eq("ld24b_err", {31'd0, ld_err}, 32'd1);

        // minute button with bounce, clock stopped
        do_load(4'd0, 4'd0, 4'd5, 4'd9);
        run = 1'b1;
        wait_cycles(25);
        run = 1'b0;
        check_eq("pre_btn_m", {8'h0, now_t()}, 32'h005902);
        btn_m = 1'b1;
        @(negedge clk);
        btn_m = 1'b0;
        @(negedge clk);
        btn_m = 1'b1;
        wait_cycles(20);
        check_eq("btn_m_held", {8'h0, now_t()}, 32'h000002);
        btn_m = 1'b0;
        wait_cycles(20);
        check_eq("btn_m_rel", {8'h0, now_t()}, 32'h000002);

        do_load(4'd2, 4'd3, 4'd4, 4'd5);
        btn_h = 1'b1;
        wait_cycles(10);
        check_eq("btn_h_held", {8'h0, now_t()}, 32'h004500);
        btn_h = 1'b0;
        wait_cycles(10);
        check_eq("btn_h_rel", {8'h0, now_t()}, 32'h004500);

        do_load(4'd0, 4'd9, 4'd5, 4'd9);
        btn_h = 1'b1;
        btn_m = 1'b1;
        wait_cycles(10);
        check_eq("btn_both", {8'h0, now_t()}, 32'h100000);
        btn_h = 1'b0;
        btn_m = 1'b0;
        wait_cycles(10);

        // increment landing on the tick edge at :09
        run = 1'b1;
        do_load(4'd1, 4'd0, 4'd2, 4'd0);
        for (int i = 1; i <= 120; i++) begin
            @(negedge clk);
            if (i == 94)
                btn_m = 1'b1;
            if (i == 104)
                btn_m = 1'b0;
            if (i == 99)
                check_eq("coll_pre", {8'h0, now_t()}, 32'h102009);
            if (i == 100) begin
                check_eq("coll_time", {8'h0, now_t()}, 32'h102109);
                check_eq("coll_tick", {31'd0, sec_tick}, 32'd1);
            end
            if (i == 110)
                check_eq("coll_next", {8'h0, now_t()}, 32'h102110);
            if (i == 120)
                check_eq("coll_next2", {8'h0, now_t()}, 32'h102111);
        end

        // reset mid-second
        do_load(4'd1, 4'd2, 4'd3, 4'd4);
        for (int i = 1; i <= 565; i++) begin
            @(negedge clk);
            if (i == 560)
                check_eq("t_123456", {8'h0, now_t()}, 32'h123456);
        end
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_time", {8'h0, now_t()}, 32'h0);
        check_eq("arst_dots", {31'd0, dots_on}, 32'd0);
        check_eq("arst_ready", {31'd0, ld_ready}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            check_eq($sformatf("rtick_c%0d", i), {31'd0, sec_tick}, (i == 10) ? 32'd1 : 32'd0);
            if (i == 9)
                check_eq("rst_t9", {8'h0, now_t()}, 32'h000000);
            if (i == 10)
                check_eq("rst_t10", {8'h0, now_t()}, 32'h000001);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
